// File: rtl/cache_tag_plru.sv
// -----------------------------------------------------------------------------
// cache_tag_plru
//
// Set-associative tag array with a tree pseudo-LRU per set, a registered
// one-cycle lookup and a sequenced flush-all engine.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   access_en_i             start a lookup this cycle
//   access_set_idx_i        set to look up
//   access_tag_i            tag to compare
//   access_valid_out_o      lookup result valid (cycle after access_en_i)
//   access_hit_oh_o         one-hot hit vector (all hitting ways reported)
//   access_hit_o            OR of access_hit_oh_o
//   access_hit_way_idx_o    lowest hitting way
//   lru_way_idx_o           PLRU victim of the looked-up set, sampled before
//                           that lookup's own touch; holds when no result
//   update_en_i             write tag/valid
//   update_way_idx_i        way to write
//   update_set_idx_i        set to write
//   update_tag_i            tag to store
//   update_valid_i          valid bit to store (0 invalidates, no PLRU touch)
//   flush_req_i             pulse: invalidate the whole array
//   flush_busy_o            flush in progress
//   flush_state_dbg_o       flush FSM state (0 = IDLE, 1 = FLUSH)
//
// Handshake: there is no backpressure. access_en_i / update_en_i /
// flush_req_i are accepted in any cycle where the flush FSM is IDLE and are
// silently dropped while flush_busy_o is high. A lookup accepted in cycle N
// always presents its result in cycle N+1 with access_valid_out_o = 1.
// -----------------------------------------------------------------------------
module cache_tag_plru #(
    parameter int NUM_WAYS        = 4,
    parameter int NUM_SETS        = 16,
    parameter int CACHE_TAG_WIDTH = 22,
    parameter int NUM_WAYS_LOG    = $clog2(NUM_WAYS),
    parameter int NUM_SETS_LOG    = $clog2(NUM_SETS)
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       access_en_i,
    input  logic [NUM_SETS_LOG-1:0]    access_set_idx_i,
    input  logic [CACHE_TAG_WIDTH-1:0] access_tag_i,
    output logic                       access_valid_out_o,
    output logic [NUM_WAYS-1:0]        access_hit_oh_o,
    output logic                       access_hit_o,
    output logic [NUM_WAYS_LOG-1:0]    access_hit_way_idx_o,
    output logic [NUM_WAYS_LOG-1:0]    lru_way_idx_o,

    input  logic                       update_en_i,
    input  logic [NUM_WAYS_LOG-1:0]    update_way_idx_i,
    input  logic [NUM_SETS_LOG-1:0]    update_set_idx_i,
    input  logic [CACHE_TAG_WIDTH-1:0] update_tag_i,
    input  logic                       update_valid_i,

    input  logic                       flush_req_i,
    output logic                       flush_busy_o,
    output logic                       flush_state_dbg_o
);

    localparam int NODES = NUM_WAYS - 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    // -------------------------------------------------------------------------
    // Tree PLRU helpers. Nodes are heap-ordered: node 0 is the root, children
    // of node n are 2n+1 (lower half) and 2n+2 (upper half). A node bit of 0
    // means the victim lies in the lower half.
    // -------------------------------------------------------------------------
    function automatic logic [NUM_WAYS_LOG-1:0] plru_victim(input logic [NODES-1:0] bits);
        logic [NUM_WAYS_LOG-1:0] v;
        int node;
        v    = '0;
        node = 0;
        for (int l = 0; l < NUM_WAYS_LOG; l++) begin
            v[NUM_WAYS_LOG-1-l] = bits[node];
            node = 2 * node + 1 + (bits[node] ? 1 : 0);
        end
        return v;
    endfunction

    // Every node on the way's path is set to point at the other subtree.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [NUM_WAYS_LOG-1:0] way);
        logic [NODES-1:0] r;
        int node;
        r    = bits;
        node = 0;
        for (int l = 0; l < NUM_WAYS_LOG; l++) begin
            r[node] = ~way[NUM_WAYS_LOG-1-l];
            node = 2 * node + 1 + (way[NUM_WAYS_LOG-1-l] ? 1 : 0);
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [CACHE_TAG_WIDTH-1:0] tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]        valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]        valid_d [NUM_SETS];
    logic [NODES-1:0]           plru_q  [NUM_SETS];
    logic [NODES-1:0]           plru_d  [NUM_SETS];

    // Lookup pipeline registers
    logic                       look_valid_q, look_valid_d;
    logic [NUM_WAYS-1:0]        hit_oh_q, hit_oh_d;
    logic [NUM_WAYS_LOG-1:0]    lru_q, lru_d;
    logic [NUM_SETS_LOG-1:0]    look_set_q, look_set_d;

    // Flush FSM
    flush_state_e               state_q, state_d;
    logic [NUM_SETS_LOG-1:0]    flush_cnt_q, flush_cnt_d;
    logic                       fsm_idle;
    logic                       flush_clear;

    logic                       access_accept;
    logic                       update_accept;
    logic [NUM_WAYS-1:0]        hit_vec;
    logic [NUM_WAYS_LOG-1:0]    hit_way;
    logic                       hit_touch;

    assign access_accept = access_en_i && fsm_idle;
    assign update_accept = update_en_i && fsm_idle;

    // -------------------------------------------------------------------------
    // Flush FSM: state register / next-state / outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == NUM_SETS_LOG'(NUM_SETS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fsm_idle          = (state_q == ST_IDLE);
        flush_clear       = (state_q == ST_FLUSH);
        flush_busy_o      = (state_q == ST_FLUSH);
        flush_state_dbg_o = state_q;
    end

    // -------------------------------------------------------------------------
    // Lookup: compare against the array as it stands in the request cycle, so
    // a same-cycle update is not visible.
    // -------------------------------------------------------------------------
    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid_q[access_set_idx_i][w] &&
                         (tag_q[access_set_idx_i][w] == access_tag_i);
        end
    end

    always_comb begin
        look_valid_d = access_accept;
        hit_oh_d     = access_accept ? hit_vec : '0;
        lru_d        = access_accept ? plru_victim(plru_q[access_set_idx_i]) : lru_q;
        look_set_d   = access_accept ? access_set_idx_i : look_set_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            look_valid_q <= 1'b0;
            hit_oh_q     <= '0;
            lru_q        <= '0;
            look_set_q   <= '0;
        end else begin
            look_valid_q <= look_valid_d;
            hit_oh_q     <= hit_oh_d;
            lru_q        <= lru_d;
            look_set_q   <= look_set_d;
        end
    end

    // Lowest hitting way wins when several ways hit.
    always_comb begin
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_oh_q[w]) begin
                hit_way = NUM_WAYS_LOG'(w);
            end
        end
    end

    assign hit_touch            = look_valid_q && (|hit_oh_q);
    assign access_valid_out_o   = look_valid_q;
    assign access_hit_oh_o      = hit_oh_q;
    assign access_hit_o         = |hit_oh_q;
    assign access_hit_way_idx_o = hit_way;
    assign lru_way_idx_o        = lru_q;

    // -------------------------------------------------------------------------
    // Valid / PLRU next state. Order matters on a shared set: hit touch, then
    // update touch (update wins on shared bits), then the flush clear, which
    // overrides everything for the set being flushed.
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        if (update_accept) begin
            valid_d[update_set_idx_i][update_way_idx_i] = update_valid_i;
        end
        if (flush_clear) begin
            valid_d[flush_cnt_q] = '0;
        end
    end

    always_comb begin
        plru_d = plru_q;
        if (hit_touch) begin
            plru_d[look_set_q] = plru_touch(plru_d[look_set_q], hit_way);
        end
        if (update_accept && update_valid_i) begin
            plru_d[update_set_idx_i] = plru_touch(plru_d[update_set_idx_i], update_way_idx_i);
        end
        if (flush_clear) begin
            plru_d[flush_cnt_q] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            plru_q  <= plru_d;
        end
    end

    // Tag storage carries no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (update_accept) begin
            tag_q[update_set_idx_i][update_way_idx_i] <= update_tag_i;
        end
    end

endmodule

// File: tb/tb_cache_tag_plru.sv
// -----------------------------------------------------------------------------
// tb_cache_tag_plru
//
// Directed bench for cache_tag_plru (4 ways, 16 sets, 22-bit tags). Expected
// lookup results are pushed to exp_q when a lookup is driven and popped by a
// monitor when access_valid_out rises. Inputs change #1 after the rising edge
// (or on the falling edge); outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cache_tag_plru;

    localparam int NW = 4;
    localparam int NS = 16;
    localparam int TW = 22;
    localparam int WL = 2;
    localparam int SL = 4;
    localparam int EW = NW + 2 * WL;  // {hit_oh, hit_way, lru}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          access_en = 1'b0;
    logic [SL-1:0] access_set_idx = '0;
    logic [TW-1:0] access_tag = '0;
    logic          access_valid_out;
    logic [NW-1:0] access_hit_oh;
    logic          access_hit;
    logic [WL-1:0] access_hit_way_idx;
    logic [WL-1:0] lru_way_idx;
    logic          update_en = 1'b0;
    logic [WL-1:0] update_way_idx = '0;
    logic [SL-1:0] update_set_idx = '0;
    logic [TW-1:0] update_tag = '0;
    logic          update_valid = 1'b0;
    logic          flush_req = 1'b0;
    logic          flush_busy;
    logic          flush_state_dbg;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;
    int            n_checks = 0;
    int            n_pass = 0;
    logic          expect_accept = 1'b1;
    logic          acc_d1 = 1'b0;
    logic          mon_en = 1'b0;
    int            busy_cnt;

    cache_tag_plru #(
        .NUM_WAYS        (NW),
        .NUM_SETS        (NS),
        .CACHE_TAG_WIDTH (TW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .access_en_i          (access_en),
        .access_set_idx_i     (access_set_idx),
        .access_tag_i         (access_tag),
        .access_valid_out_o   (access_valid_out),
        .access_hit_oh_o      (access_hit_oh),
        .access_hit_o         (access_hit),
        .access_hit_way_idx_o (access_hit_way_idx),
        .lru_way_idx_o        (lru_way_idx),
        .update_en_i          (update_en),
        .update_way_idx_i     (update_way_idx),
        .update_set_idx_i     (update_set_idx),
        .update_tag_i         (update_tag),
        .update_valid_i       (update_valid),
        .flush_req_i          (flush_req),
        .flush_busy_o         (flush_busy),
        .flush_state_dbg_o    (flush_state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One lookup followed by an idle cycle so its hit touch has landed before
    // the next request samples the PLRU bits.
    task automatic lookup(input logic [SL-1:0] set, input logic [TW-1:0] tag,
                          input logic [NW-1:0] e_oh, input logic [WL-1:0] e_way,
                          input logic [WL-1:0] e_lru);
        access_en      = 1'b1;
        access_set_idx = set;
        access_tag     = tag;
        exp_q.push_back({e_oh, e_way, e_lru});
        tick();
        access_en = 1'b0;
        tick();
    endtask

    task automatic update(input logic [WL-1:0] way, input logic [SL-1:0] set,
                          input logic [TW-1:0] tag, input logic valid);
        update_en      = 1'b1;
        update_way_idx = way;
        update_set_idx = set;
        update_tag     = tag;
        update_valid   = valid;
        tick();
        update_en = 1'b0;
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(posedge clk) acc_d1 <= access_en && expect_accept;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("valid_out", 32'(access_valid_out), 32'(acc_d1));
            if (access_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("q_depth", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("hit_oh", 32'(access_hit_oh), 32'(e[EW-1 -: NW]));
                    check("hit", 32'(access_hit), 32'(|e[EW-1 -: NW]));
                    check("hit_way", 32'(access_hit_way_idx), 32'(e[2*WL-1 -: WL]));
                    check("lru", 32'(lru_way_idx), 32'(e[WL-1:0]));
                end
            end else begin
                check("idle_oh", 32'(access_hit_oh), 32'd0);
                check("idle_hit", 32'(access_hit), 32'd0);
                check("idle_way", 32'(access_hit_way_idx), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(access_valid_out), 32'd0);
        check("rst_oh", 32'(access_hit_oh), 32'd0);
        check("rst_hit", 32'(access_hit), 32'd0);
        check("rst_way", 32'(access_hit_way_idx), 32'd0);
        check("rst_lru", 32'(lru_way_idx), 32'd0);
        check("rst_busy", 32'(flush_busy), 32'd0);
        check("rst_state", 32'(flush_state_dbg), 32'd0);
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Post-reset lookup misses, victim 0
        lookup(4'd3, 22'h12345, 4'b0000, 2'd0, 2'd0);

        // Fill and hit
        update(2'd2, 4'd5, 22'hABC, 1'b1);
        lookup(4'd5, 22'hABC, 4'b0100, 2'd2, 2'd0);
        lookup(4'd5, 22'hABD, 4'b0000, 2'd0, 2'd0);

        // PLRU order in set 7, then hit touches
        lookup(4'd7, 22'h999, 4'b0000, 2'd0, 2'd0);
        update(2'd0, 4'd7, 22'h70, 1'b1);
        lookup(4'd7, 22'h999, 4'b0000, 2'd0, 2'd2);
        update(2'd2, 4'd7, 22'h72, 1'b1);
        lookup(4'd7, 22'h999, 4'b0000, 2'd0, 2'd1);
        update(2'd1, 4'd7, 22'h71, 1'b1);
        lookup(4'd7, 22'h999, 4'b0000, 2'd0, 2'd3);
        lookup(4'd7, 22'h70, 4'b0001, 2'd0, 2'd3);
        lookup(4'd7, 22'h72, 4'b0100, 2'd2, 2'd3);
        lookup(4'd7, 22'h999, 4'b0000, 2'd0, 2'd1);

        // Same-cycle update/lookup: lookup sees the old contents
        update_en = 1'b1; update_way_idx = 2'd1; update_set_idx = 4'd4;
        update_tag = 22'h7; update_valid = 1'b1;
        access_en = 1'b1; access_set_idx = 4'd4; access_tag = 22'h7;
        exp_q.push_back({4'b0000, 2'd0, 2'd0});
        tick();
        update_en = 1'b0;
        access_en = 1'b0;
        lookup(4'd4, 22'h7, 4'b0010, 2'd1, 2'd2);

        // Multiple hits reported, lowest way encoded; invalidate skips touch
        update(2'd3, 4'd4, 22'h7, 1'b1);
        lookup(4'd4, 22'h7, 4'b1010, 2'd1, 2'd0);
        update(2'd3, 4'd4, 22'h7, 1'b0);
        lookup(4'd4, 22'h7, 4'b0010, 2'd1, 2'd2);

        // Flush: fill sets 0 and 15, lookup accepted alongside flush_req
        for (int w = 0; w < NW; w++) update(WL'(w), 4'd0, TW'(32'h100 + w), 1'b1);
        for (int w = 0; w < NW; w++) update(WL'(w), 4'd15, TW'(32'h1F0 + w), 1'b1);
        flush_req = 1'b1;
        access_en = 1'b1; access_set_idx = 4'd0; access_tag = 22'h100;
        exp_q.push_back({4'b0001, 2'd0, 2'd0});
        tick();
        flush_req = 1'b0;
        access_en = 1'b0;
        busy_cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (flush_busy) busy_cnt++;
            if (i == 3) begin
                // all of these must be ignored while flushing
                expect_accept = 1'b0;
                access_en = 1'b1; access_set_idx = 4'd0; access_tag = 22'h100;
                update_en = 1'b1; update_way_idx = 2'd0; update_set_idx = 4'd0;
                update_tag = 22'h555; update_valid = 1'b1;
                flush_req = 1'b1;
            end
            if (i == 4) begin
                access_en = 1'b0;
                update_en = 1'b0;
                flush_req = 1'b0;
                expect_accept = 1'b1;
            end
            if (!flush_busy && busy_cnt > 0) break;
        end
        check("flush_len", 32'(busy_cnt), 32'd16);
        tick();

        lookup(4'd0, 22'h100, 4'b0000, 2'd0, 2'd0);
        lookup(4'd0, 22'h103, 4'b0000, 2'd0, 2'd0);
        lookup(4'd0, 22'h555, 4'b0000, 2'd0, 2'd0);
        lookup(4'd15, 22'h1F3, 4'b0000, 2'd0, 2'd0);
        lookup(4'd7, 22'h70, 4'b0000, 2'd0, 2'd0);
        lookup(4'd5, 22'hABC, 4'b0000, 2'd0, 2'd0);
        lookup(4'd4, 22'h7, 4'b0000, 2'd0, 2'd0);

        // Reset in the middle of a flush
        for (int w = 0; w < NW; w++) update(WL'(w), 4'd15, TW'(32'h1F0 + w), 1'b1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("pre_rst_busy", 32'(flush_busy), 32'd1);
        check("pre_rst_state", 32'(flush_state_dbg), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy_now", 32'(flush_busy), 32'd0);
        check("rst_valid_now", 32'(access_valid_out), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int w = 0; w < NW; w++) lookup(4'd15, TW'(32'h1F0 + w), 4'b0000, 2'd0, 2'd0);
        lookup(4'd0, 22'h100, 4'b0000, 2'd0, 2'd0);

        repeat (3) tick();
        check("q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
